// File: rtl/note_tick_gen.sv
// Beat generator for the rhythm game: turns the difficulty period into a one-cycle
// tick while in play mode, counts beats up to the song length, then waits in DONE.
module note_tick_gen #(
    parameter logic [2:0] PLAY_MODE      = 3'd2,
    parameter int         DEFAULT_PERIOD = 5000000,
    parameter int         MIN_PERIOD     = 2,
    parameter int         SONG_LEN       = 64,
    parameter int         BEAT_W         = 6
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [2:0]        mode,
    input  logic [22:0]       diff_speed,
    input  logic              pause,
    output logic              tick,
    output logic [BEAT_W-1:0] beat,
    output logic              running,
    output logic              song_done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [22:0]       DEF_PERIOD = 23'(DEFAULT_PERIOD);
    localparam logic [22:0]       MIN_P      = 23'(MIN_PERIOD);
    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(SONG_LEN - 1);

    logic [1:0]  state;
    logic [22:0] cnt;
    logic [22:0] cur_period;
    logic [22:0] clamped_speed;
    logic        in_play;
    logic        period_end;

    // The period is only ever sampled through this clamp, so a zero or one request
    // can never stall the counter or make it wrap.
    assign clamped_speed = (diff_speed < MIN_P) ? MIN_P : diff_speed;
    assign in_play       = (mode == PLAY_MODE);
    assign period_end    = (cnt == cur_period - 23'd1);

    assign tick      = (state == RUN) && in_play && !pause && period_end;
    assign running   = (state == RUN);
    assign song_done = (state == DONE);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            cnt        <= '0;
            beat       <= '0;
            cur_period <= DEF_PERIOD;
        end else begin
            case (state)
                RUN: begin
                    // Leaving play mode wins over both pause and a pending tick.
                    if (!in_play) begin
                        state <= IDLE;
                        cnt   <= '0;
                        beat  <= '0;
                    end else if (!pause) begin
                        if (period_end) begin
                            cnt        <= '0;
                            cur_period <= clamped_speed;
                            if (beat == LAST_BEAT) begin
                                state <= DONE;
                            end else begin
                                beat <= beat + BEAT_W'(1);
                            end
                        end else begin
                            cnt <= cnt + 23'd1;
                        end
                    end
                end
                DONE: begin
                    if (!in_play) begin
                        state <= IDLE;
                        cnt   <= '0;
                        beat  <= '0;
                    end
                end
                default: begin
                    cnt  <= '0;
                    beat <= '0;
                    if (in_play) begin
                        state      <= RUN;
                        cur_period <= clamped_speed;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_note_tick_gen.sv
// Self-checking bench for note_tick_gen: directed beat-timing scenarios plus a
// randomized run, all compared against a remaining-clocks model of the beat.
module tb_note_tick_gen;

    localparam int SONG_LEN = 4;
    localparam int BEAT_W   = 6;

    logic              clk = 1'b0;
    logic              n_rst = 1'b0;
    logic [2:0]        mode = 3'd0;
    logic [22:0]       diff_speed = 23'd5;
    logic              pause = 1'b0;
    logic              tick;
    logic [BEAT_W-1:0] beat;
    logic              running;
    logic              song_done;

    int checks = 0;
    int fails  = 0;

    note_tick_gen #(
        .PLAY_MODE(3'd2),
        .DEFAULT_PERIOD(8),
        .MIN_PERIOD(2),
        .SONG_LEN(SONG_LEN),
        .BEAT_W(BEAT_W)
    ) dut (
        .clk(clk),
        .n_rst(n_rst),
        .mode(mode),
        .diff_speed(diff_speed),
        .pause(pause),
        .tick(tick),
        .beat(beat),
        .running(running),
        .song_done(song_done)
    );

    always #5 clk = ~clk;

    // Model: 0 idle, 1 playing, 2 finished; m_rem counts clocks left until the beat.
    int m_state;
    int m_rem;
    int m_beat;
    int tick_times[$];

    function automatic int clamp2(input int v);
        return (v < 2) ? 2 : v;
    endfunction

    function automatic logic exp_tick();
        return (m_state == 1) && (mode == 3'd2) && !pause && (m_rem == 1);
    endfunction

    function automatic logic [8:0] exp_vec();
        return {exp_tick(), m_state == 1, m_state == 2, 6'(m_beat)};
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_rem   = 0;
        m_beat  = 0;
    endtask

    task automatic model_step();
        if (m_state == 1) begin
            if (mode != 3'd2) begin
                m_state = 0;
                m_beat  = 0;
            end else if (!pause) begin
                if (m_rem == 1) begin
                    m_rem = clamp2(int'(diff_speed));
                    if (m_beat == SONG_LEN - 1) m_state = 2;
                    else m_beat++;
                end else begin
                    m_rem--;
                end
            end
        end else if (m_state == 2) begin
            if (mode != 3'd2) begin
                m_state = 0;
                m_beat  = 0;
            end
        end else if (mode == 3'd2) begin
            m_state = 1;
            m_rem   = clamp2(int'(diff_speed));
            m_beat  = 0;
        end
    endtask

    // Advance one clock; inputs are changed again 1ns after the edge.
    task automatic tick_clk();
        @(posedge clk);
        if (!n_rst) model_reset();
        else model_step();
        #1;
    endtask

    task automatic go_idle();
        mode = 3'd0;
        pause = 1'b0;
        tick_clk();
        tick_clk();
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        mode = 3'd0;
        model_reset();
        repeat (3) tick_clk();
        n_rst = 1'b1;
        tick_clk();
        @(negedge clk);
        checks++;
        if ({tick, running, song_done, beat} !== 9'd0) begin
            fails++;
            $display("[TB] FAIL reset_outputs: got %b expected %b", {tick, running, song_done, beat}, 9'd0);
        end
        tick_clk();
    endtask

    task automatic test_basic_song();
        int exp_t[4] = '{5, 10, 15, 20};
        tick_times.delete();
        diff_speed = 23'd5;
        mode = 3'd2;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (tick) tick_times.push_back(i);
            checks++;
            if ({tick, running, song_done, beat} !== exp_vec()) begin
                fails++;
                $display("[TB] FAIL basic_song cycle %0d: got %b expected %b", i, {tick, running, song_done, beat}, exp_vec());
            end
            if (i == 1 || i == 21) begin
                checks++;
                if ({running, song_done, beat} !== ((i == 1) ? {2'b10, 6'd0} : {2'b01, 6'd3})) begin
                    fails++;
                    $display("[TB] FAIL basic_status cycle %0d: got %b", i, {running, song_done, beat});
                end
            end
            tick_clk();
        end
        checks++;
        if (tick_times.size() != 4) begin
            fails++;
            $display("[TB] FAIL basic_tick_count: got %0d expected 4", tick_times.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (tick_times[k] != exp_t[k]) begin
                    fails++;
                    $display("[TB] FAIL basic_tick_time %0d: got %0d expected %0d", k, tick_times[k], exp_t[k]);
                end
            end
        end
        mode = 3'd0;
        tick_clk();
        @(negedge clk);
        checks++;
        if ({running, song_done, beat} !== 8'd0) begin
            fails++;
            $display("[TB] FAIL done_to_idle: got %b expected %b", {running, song_done, beat}, 8'd0);
        end
        mode = 3'd2;
        tick_clk();
        @(negedge clk);
        checks++;
        if ({tick, running, song_done, beat} !== {3'b010, 6'd0}) begin
            fails++;
            $display("[TB] FAIL new_song: got %b expected %b", {tick, running, song_done, beat}, {3'b010, 6'd0});
        end
        tick_clk();
    endtask

    task automatic test_period_change();
        int exp_t[4] = '{5, 8, 11, 14};
        go_idle();
        tick_times.delete();
        diff_speed = 23'd5;
        mode = 3'd2;
        for (int i = 0; i < 16; i++) begin
            if (i == 2) diff_speed = 23'd3;
            @(negedge clk);
            if (tick) tick_times.push_back(i);
            checks++;
            if ({tick, running, song_done, beat} !== exp_vec()) begin
                fails++;
                $display("[TB] FAIL period_change cycle %0d: got %b expected %b", i, {tick, running, song_done, beat}, exp_vec());
            end
            tick_clk();
        end
        checks++;
        if (tick_times.size() != 4 || tick_times[0] != exp_t[0] || tick_times[1] != exp_t[1]
            || tick_times[3] != exp_t[3]) begin
            fails++;
            $display("[TB] FAIL period_change_times: got %p expected %p", tick_times, exp_t);
        end
    endtask

    task automatic test_min_clamp();
        for (int v = 0; v < 2; v++) begin
            go_idle();
            tick_times.delete();
            diff_speed = 23'(v);
            mode = 3'd2;
            for (int i = 0; i < 9; i++) begin
                @(negedge clk);
                if (tick) tick_times.push_back(i);
                checks++;
                if ({tick, running, song_done, beat} !== exp_vec()) begin
                    fails++;
                    $display("[TB] FAIL min_clamp speed %0d cycle %0d: got %b expected %b", v, i, {tick, running, song_done, beat}, exp_vec());
                end
                tick_clk();
            end
            checks++;
            if (tick_times.size() != 4 || tick_times[0] != 2 || tick_times[3] != 8) begin
                fails++;
                $display("[TB] FAIL min_clamp_times speed %0d: got %p expected 2,4,6,8", v, tick_times);
            end
        end
    endtask

    task automatic test_pause();
        go_idle();
        tick_times.delete();
        diff_speed = 23'd5;
        mode = 3'd2;
        for (int i = 0; i < 22; i++) begin
            pause = ((i >= 3 && i <= 9) || (i >= 17 && i <= 19));
            @(negedge clk);
            if (tick) tick_times.push_back(i);
            checks++;
            if ({tick, running, song_done, beat} !== exp_vec()) begin
                fails++;
                $display("[TB] FAIL pause cycle %0d: got %b expected %b", i, {tick, running, song_done, beat}, exp_vec());
            end
            tick_clk();
        end
        pause = 1'b0;
        checks++;
        if (tick_times.size() != 2 || tick_times[0] != 12 || tick_times[1] != 20) begin
            fails++;
            $display("[TB] FAIL pause_times: got %p expected 12,20", tick_times);
        end
    endtask

    task automatic test_mode_exit_on_tick();
        go_idle();
        tick_times.delete();
        diff_speed = 23'd5;
        mode = 3'd2;
        for (int i = 0; i < 8; i++) begin
            if (i == 5) mode = 3'd0;
            @(negedge clk);
            if (tick) tick_times.push_back(i);
            checks++;
            if ({tick, running, song_done, beat} !== exp_vec()) begin
                fails++;
                $display("[TB] FAIL mode_exit cycle %0d: got %b expected %b", i, {tick, running, song_done, beat}, exp_vec());
            end
            tick_clk();
        end
        checks++;
        if (tick_times.size() != 0 || running !== 1'b0 || beat !== 6'd0) begin
            fails++;
            $display("[TB] FAIL mode_exit_final: got ticks=%0d running=%b beat=%0d expected 0,0,0", tick_times.size(), running, beat);
        end
    endtask

    task automatic test_random();
        go_idle();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(99) < 4) mode = 3'($urandom_range(7));
            else if ($urandom_range(99) < 20) mode = 3'd2;
            if ($urandom_range(99) < 15) diff_speed = 23'($urandom_range(6));
            pause = ($urandom_range(99) < 25);
            @(negedge clk);
            checks++;
            if ({tick, running, song_done, beat} !== exp_vec()) begin
                fails++;
                $display("[TB] FAIL random cycle %0d: got %b expected %b", i, {tick, running, song_done, beat}, exp_vec());
            end
            tick_clk();
        end
        pause = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        go_idle();
        diff_speed = 23'd4;
        mode = 3'd2;
        repeat (6) tick_clk();
        n_rst = 1'b0;
        #1;
        checks++;
        if ({tick, running, song_done, beat} !== 9'd0) begin
            fails++;
            $display("[TB] FAIL reset_mid_run: got %b expected %b", {tick, running, song_done, beat}, 9'd0);
        end
        model_reset();
        mode = 3'd0;
        repeat (2) tick_clk();
        n_rst = 1'b1;
        tick_clk();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic_song();
        test_period_change();
        test_min_clamp();
        test_pause();
        test_mode_exit_on_tick();
        test_random();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
